// File: rtl/solver_result_packer.sv
// Packs the solver's 1-bit result stream LSB-first into WIDTH-bit words.
// Each word is queued with its popcount in a DEPTH-entry FIFO and drained over valid/ready.
module solver_result_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     f_in,
    input  logic                     f_valid,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic [CW-1:0]            out_ones,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned BW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    ones;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    ones_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [WIDTH-1:0] word_cur;
    logic [CW-1:0]    ones_cur;
    logic             word_done;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;
    logic [PW-1:0]    rd_inc;

    logic [WIDTH-1:0] word_d;
    logic [CW-1:0]    ones_d;
    logic [BW-1:0]    bit_cnt_d;
    logic [LW-1:0]    level_d;
    logic [WIDTH-1:0] head_data_d;
    logic [CW-1:0]    head_ones_d;
    logic             overflow_d;

    // Packing, FIFO bookkeeping and next head-of-queue selection
    always_comb begin
        word_cur    = word_q;
        ones_cur    = ones_q + CW'(f_valid & f_in);
        word_done   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        full        = 1'b0;
        accept      = 1'b0;
        drop        = 1'b0;
        rd_inc      = rd_ptr + PW'(1);
        word_d      = word_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt;
        level_d     = level;
        head_data_d = out_data;
        head_ones_d = out_ones;
        overflow_d  = overflow;

        if (f_valid) begin
            word_cur[bit_cnt] = f_in;
        end

        word_done = f_valid && (bit_cnt == BW'(WIDTH - 1));
        push      = word_done || (flush && ((bit_cnt != '0) || f_valid));
        pop       = out_valid && out_ready;
        full      = (level == LW'(DEPTH));
        accept    = push && (!full || pop);
        drop      = push && full && !pop;

        // The partial word keeps filling regardless of FIFO state
        if (push) begin
            word_d    = '0;
            ones_d    = '0;
            bit_cnt_d = '0;
        end else if (f_valid) begin
            word_d    = word_cur;
            ones_d    = ones_cur;
            bit_cnt_d = bit_cnt + BW'(1);
        end

        case ({accept, pop})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end

        // Head register tracks what mem[rd_ptr] will hold after this edge
        if (level_d == '0) begin
            head_data_d = '0;
            head_ones_d = '0;
        end else if (level == '0 || (pop && level == LW'(1))) begin
            head_data_d = word_cur;
            head_ones_d = ones_cur;
        end else if (pop) begin
            head_data_d = mem[rd_inc].data;
            head_ones_d = mem[rd_inc].ones;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            word_q    <= '0;
            ones_q    <= '0;
            bit_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            out_ones  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            word_q    <= word_d;
            ones_q    <= ones_d;
            bit_cnt   <= bit_cnt_d;
            level     <= level_d;
            out_data  <= head_data_d;
            out_ones  <= head_ones_d;
            out_valid <= (level_d != '0);
            overflow  <= overflow_d;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_inc;
            end
        end
    end

    // Storage array needs no reset: occupancy alone decides what is readable
    always_ff @(posedge clock) begin
        if (!clear && accept) begin
            mem[wr_ptr] <= '{data: word_cur, ones: ones_cur};
        end
    end

endmodule

// File: tb/tb_solver_result_packer.sv
// Bench for solver_result_packer: directed scenarios then random traffic,
// compared every cycle against a queue-based model of the packer and FIFO.
module tb_solver_result_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned BW    = $clog2(WIDTH);

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic             f_in = 1'b0;
    logic             f_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_ones;
    logic             out_valid;
    logic [LW-1:0]    level;
    logic [BW-1:0]    bit_cnt;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] mq[$];
    bit               pbits[$];
    bit               m_ovf = 1'b0;

    solver_result_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .clear     (clear),
        .f_in      (f_in),
        .f_valid   (f_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_ones  (out_ones),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .bit_cnt   (bit_cnt),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a list of pending bits and a bounded queue of finished words
    task automatic model_step();
        bit               do_pop;
        bit               do_push;
        logic [WIDTH-1:0] w;
        do_pop  = 1'b0;
        do_push = 1'b0;
        w       = '0;
        if (clear) begin
            mq.delete();
            pbits.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop = (mq.size() > 0) && out_ready;
            if (f_valid) pbits.push_back(f_in);
            if (pbits.size() == int'(WIDTH) || (flush && pbits.size() > 0)) begin
                foreach (pbits[i]) w[i] = pbits[i];
                pbits.delete();
                do_push = 1'b1;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < int'(DEPTH)) mq.push_back(w);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [WIDTH-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".valid"},    32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".data"},     32'(out_data),  32'(head));
        chk({tag, ".ones"},     32'(out_ones),  32'($countones(head)));
        chk({tag, ".level"},    32'(level),     32'(mq.size()));
        chk({tag, ".bit_cnt"},  32'(bit_cnt),   32'(pbits.size()));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    task automatic step(input bit c, input bit fv, input bit fi, input bit fl,
                        input bit rdy, input string tag);
        clear     = c;
        f_valid   = fv;
        f_in      = fi;
        flush     = fl;
        out_ready = rdy;
        @(posedge clock);
        model_step();
        #1;
        check_state(tag);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit last_rdy, input string tag);
        for (int i = 0; i < int'(WIDTH); i++)
            step(1'b0, 1'b1, w[i], 1'b0, (i == int'(WIDTH) - 1) ? last_rdy : 1'b0, tag);
    endtask

    initial begin
        logic [WIDTH-1:0] pat;

        // Reset held two cycles with live input
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rst0");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rst1");
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_bitcnt", 32'(bit_cnt), 32'd0);

        // Pack 1,0,1,1,0,0,0,1 -> 0x8D
        pat = 8'h8D;
        send_word(pat, 1'b0, "pack");
        chk("pack_data", 32'(out_data), 32'h8D);
        chk("pack_ones", 32'(out_ones), 32'd4);
        chk("pack_level", 32'(level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pack_pop");

        // Flush alone after 1,1,0
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fl1");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fl1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fl1");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fl1_go");
        chk("flush_data", 32'(out_data), 32'h03);
        chk("flush_ones", 32'(out_ones), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fl_noop_pop");
        chk("flush_noop_level", 32'(level), 32'd0);

        // Flush together with the third bit
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fl2");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "fl2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "fl2_go");
        chk("flush2_data", 32'(out_data), 32'h07);
        chk("flush2_ones", 32'(out_ones), 32'd3);

        // Overflow: five words into a four-deep FIFO
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ovf_clr");
        for (int k = 1; k <= 5; k++) send_word(WIDTH'(k), 1'b0, "ovf_fill");
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", 32'(out_data), 32'(k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_pop");
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with push and pop on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fpp_clr");
        for (int k = 0; k < 4; k++) send_word(WIDTH'(8'h11 + k), 1'b0, "fpp_fill");
        send_word(8'h15, 1'b1, "fpp_both");
        chk("fpp_level", 32'(level), 32'd4);
        chk("fpp_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("fpp_order", 32'(out_data), 32'(8'h12 + k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fpp_pop");
        end

        // Clear in the middle of a word
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "mid_bits");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_clr");
        send_word(8'hFF, 1'b0, "mid_ff");
        chk("mid_data", 32'(out_data), 32'hFF);
        chk("mid_ones", 32'(out_ones), 32'd8);
        chk("mid_level", 32'(level), 32'd1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 249) == 0, 1'($urandom()), 1'($urandom()),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
